idct_mcu_scheduler: RTL
=======================

Name: idct_mcu_scheduler

Overview:
- Time-shares one dq_idct channel path between the Y, U and V zigzag_to_matrix buffers, in JPEG MCU order.
- For an MCU with N luma blocks the order is Y0..Y(N-1), then U, then V; the grant is held for a whole 64-coefficient block.
- Sits between the three zigzag_to_matrix instances and the dq_idct input.
- Drives the DQT table select and the component tag so downstream line-buffer writes go to the correct plane.

Parameters:
- DATA_W, 16, amplitude precision of one coefficient.
- PX_OUT, 1, coefficients per beat in x.
- PY_OUT, 1, coefficients per beat in y.
- BLK_SIZE, 64, coefficients per 8x8 block.
- Y_BLOCKS_MAX, 4, maximum luma blocks per MCU.

Ports:
- r_srst  in  1  reset, asynchronous, active-high.
- r_sysclk  in  1  clock.
- i_en  in  1  start/continue MCU sequencing.
- i_cfg_y_blocks  in  3  luma blocks per MCU (1..4); sampled at each MCU start.
- i_Y_nempty / i_U_nempty / i_V_nempty  in  1 each  source buffer holds data.
- i_Y_md / i_U_md / i_V_md  in  PY_OUT*PX_OUT*DATA_W each  source matrix data.
- o_Y_re / o_U_re / o_V_re  out  1 each  source read enables.
- i_lb_full  in  3  line-buffer full per plane: [0]=Y, [1]=U, [2]=V.
- o_de  out  1  output beat valid.
- o_md  out  PY_OUT*PX_OUT*DATA_W  muxed data.
- i_re  in  1  downstream accepts a beat.
- o_comp  out  2  component of the current beat: 0=Y, 1=U, 2=V.
- o_qt_sel  out  1  0=luma table, 1=chroma table.
- o_blk_start  out  1  first beat of a block.
- o_mcu_done  out  1  one-cycle pulse after the last V beat is accepted.

Behaviour:
- Beat and counter sizing:
  - BEATS = BLK_SIZE/(PX_OUT*PY_OUT); beat counter is clog2(BEATS) bits.
  - Luma block counter is 2 bits.
- States: S_IDLE, S_Y, S_U, S_V (registered).
- Reset values: state=S_IDLE, all counters 0, cfg register=1, o_mcu_done=0.
  - Combinational outputs evaluate to o_de=0 and all o_X_re=0 in S_IDLE.
  - o_comp=0, o_qt_sel=0 in S_IDLE.
- Transitions:
  - S_IDLE -> S_Y when i_en=1. On that edge, latch cfg: value 0 -> 1, values >4 -> 4.
  - S_Y: a block ends on an accepted beat with beat_cnt=BEATS-1. Then beat_cnt->0 and y_cnt++. If y_cnt=cfg-1, go to S_U and clear y_cnt.
  - S_U: after one block, go to S_V.
  - S_V: after one block, pulse o_mcu_done next cycle. Go to S_Y if i_en=1 (re-latching cfg), else S_IDLE.
- Datapath (zero latency, combinational mux):
  - sel = plane for the current state.
  - o_de = sel_nempty & ~i_lb_full[sel] & (state!=S_IDLE).
  - o_md = sel_md.
  - o_sel_re = o_de & i_re; other read enables = 0.
  - A beat is accepted when o_de & i_re.
- o_blk_start = o_de & (beat_cnt==0).
- o_qt_sel = (state==S_U or S_V).
- No preemption: a non-selected plane with data never gets a read enable until its turn.
- Stalls: if sel buffer is empty or its line buffer is full, o_de=0 and the counters hold. There is no timeout.
- i_en dropped mid-MCU: the current MCU completes, then the block idles.
- i_cfg_y_blocks changing mid-MCU has no effect until the next MCU start.
- r_srst mid-block: immediate return to the reset state. The partially read block is discarded; upstream buffers are reset by the same r_srst.

Optional Feature:
- Macro: IDCT_MCU_SCHEDULER_PERF_EN.
- Defined:
  - Adds output o_stall_cnt, 32 bits. It counts cycles with state!=S_IDLE & ~(o_de & i_re).
  - Saturates at 0xFFFFFFFF; reset to 0; cleared on the S_IDLE->S_Y transition.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package idct_sched_pkg holds:
  - state encodings S_IDLE..S_V;
  - COMP_Y=0, COMP_U=1, COMP_V=2;
  - QT_LUMA=0, QT_CHROMA=1;
  - the BEATS calculation function.
- Sub-module idct_blk_counter: beat counter with wrap and a last-beat flag, driven by the accept strobe.

Test Plan:
- cfg=4, all sources always non-empty, i_re=1, PX=PY=1:
  - o_comp sequence is 256 beats of 0, 64 of 1, 64 of 2.
  - o_mcu_done pulses at cycle 385 after start.
  - o_blk_start is seen exactly 6 times.
- cfg=1, i_U_nempty=0 for 20 cycles after Y completes:
  - o_de=0 and no o_*_re during those cycles.
  - No V reads occur before the U block.
  - With PERF_EN, o_stall_cnt=20.
- cfg=2, i_lb_full[0] asserted for 10 cycles at Y beat 30:
  - o_Y_re=0 during the stall; the beat count resumes at 30.
  - Total Y beats = 128.
- i_en deasserted during the U block of MCU0:
  - The MCU completes through V and then returns to S_IDLE.
  - No further o_*_re occur.
- r_srst pulsed at Y beat 17:
  - All o_*_re=0 and o_de=0 immediately.
  - After release with i_en=1, o_blk_start is asserted on the first beat with o_comp=0.
- cfg=0 and cfg=7:
  - Sequencing uses 1 and 4 luma blocks respectively.

Source files
------------

// File: rtl/idct_sched_pkg.sv
// Shared encodings and helpers for the IDCT MCU scheduler.
package idct_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_Y    = 2'd1,
        S_U    = 2'd2,
        S_V    = 2'd3
    } sched_state_e;

    localparam logic [1:0] COMP_Y = 2'd0;
    localparam logic [1:0] COMP_U = 2'd1;
    localparam logic [1:0] COMP_V = 2'd2;

    localparam logic QT_LUMA   = 1'b0;
    localparam logic QT_CHROMA = 1'b1;

    // Beats needed to move one block when several coefficients travel per beat.
    function automatic int unsigned calc_beats(input int unsigned blk_size,
                                               input int unsigned px,
                                               input int unsigned py);
        return blk_size / (px * py);
    endfunction

    // Luma block count of an MCU: 0 means 1, anything above the maximum saturates.
    function automatic logic [2:0] clamp_y_blocks(input logic [2:0] cfg,
                                                  input logic [2:0] max_blocks);
        logic [2:0] res;
        res = cfg;
        if (cfg == 3'd0) begin
            res = 3'd1;
        end else if (cfg > max_blocks) begin
            res = max_blocks;
        end
        return res;
    endfunction

endpackage

// File: rtl/idct_blk_counter.sv
// Beat counter for one block: advances on each accepted beat and wraps after the last one.
module idct_blk_counter #(
    parameter int unsigned BEATS = 64,
    parameter int unsigned CNT_W = 6
) (
    input  logic             r_sysclk,
    input  logic             r_srst,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output logic             last_c
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    assign last_c = (cnt == LAST_BEAT);

    // Count accepted beats and return to zero after the final beat of the block.
    always_ff @(posedge r_sysclk or posedge r_srst) begin
        if (r_srst) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= last_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/idct_mcu_scheduler.sv
// Shares one dq_idct input between the Y, U and V coefficient buffers in MCU order
// (Y0..Y(N-1), U, V), holding the grant for a whole block.
// Optional IDCT_MCU_SCHEDULER_PERF_EN adds a saturating stall-cycle counter output.
module idct_mcu_scheduler
    import idct_sched_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned PX_OUT       = 1,
    parameter int unsigned PY_OUT       = 1,
    parameter int unsigned BLK_SIZE     = 64,
    parameter int unsigned Y_BLOCKS_MAX = 4
) (
    input  logic                              r_srst,
    input  logic                              r_sysclk,
    input  logic                              i_en,
    input  logic [2:0]                        i_cfg_y_blocks,
    input  logic                              i_Y_nempty,
    input  logic                              i_U_nempty,
    input  logic                              i_V_nempty,
    input  logic [PY_OUT*PX_OUT*DATA_W-1:0]   i_Y_md,
    input  logic [PY_OUT*PX_OUT*DATA_W-1:0]   i_U_md,
    input  logic [PY_OUT*PX_OUT*DATA_W-1:0]   i_V_md,
    output logic                              o_Y_re,
    output logic                              o_U_re,
    output logic                              o_V_re,
    input  logic [2:0]                        i_lb_full,
    output logic                              o_de,
    output logic [PY_OUT*PX_OUT*DATA_W-1:0]   o_md,
    input  logic                              i_re,
    output logic [1:0]                        o_comp,
    output logic                              o_qt_sel,
    output logic                              o_blk_start,
    output logic                              o_mcu_done
`ifdef IDCT_MCU_SCHEDULER_PERF_EN
    ,
    output logic [31:0]                       o_stall_cnt
`endif
);

    localparam int unsigned BEATS  = calc_beats(BLK_SIZE, PX_OUT, PY_OUT);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [2:0]  Y_MAX  = 3'(Y_BLOCKS_MAX);

    sched_state_e      state_q, state_d;
    logic [2:0]        cfg_q, cfg_d;
    logic [1:0]        y_cnt_q, y_cnt_d;
    logic              mcu_done_d;
    logic              sel_nempty;
    logic              sel_full;
    logic              accept;
    logic              blk_end;
    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_last_c;

    idct_blk_counter #(
        .BEATS (BEATS),
        .CNT_W (BEAT_W)
    ) u_blk_counter (
        .r_sysclk (r_sysclk),
        .r_srst   (r_srst),
        .adv      (accept),
        .cnt      (beat_cnt),
        .last_c   (beat_last_c)
    );

    // Route the granted plane's status and data; nothing is granted while idle.
    always_comb begin
        sel_nempty = 1'b0;
        sel_full   = 1'b0;
        o_md       = i_Y_md;
        o_comp     = COMP_Y;
        o_qt_sel   = QT_LUMA;
        case (state_q)
            S_Y: begin
                sel_nempty = i_Y_nempty;
                sel_full   = i_lb_full[0];
            end
            S_U: begin
                sel_nempty = i_U_nempty;
                sel_full   = i_lb_full[1];
                o_md       = i_U_md;
                o_comp     = COMP_U;
                o_qt_sel   = QT_CHROMA;
            end
            S_V: begin
                sel_nempty = i_V_nempty;
                sel_full   = i_lb_full[2];
                o_md       = i_V_md;
                o_comp     = COMP_V;
                o_qt_sel   = QT_CHROMA;
            end
            default: ;
        endcase
    end

    assign o_de        = sel_nempty & ~sel_full & (state_q != S_IDLE);
    assign accept      = o_de & i_re;
    assign blk_end     = accept & beat_last_c;
    assign o_blk_start = o_de & (beat_cnt == '0);
    assign o_Y_re      = accept & (state_q == S_Y);
    assign o_U_re      = accept & (state_q == S_U);
    assign o_V_re      = accept & (state_q == S_V);

    // MCU sequencing: next state, luma block index and configuration latch.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        y_cnt_d    = y_cnt_q;
        mcu_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_en) begin
                    state_d = S_Y;
                    cfg_d   = clamp_y_blocks(i_cfg_y_blocks, Y_MAX);
                end
            end
            S_Y: begin
                if (blk_end) begin
                    if (3'(y_cnt_q) == cfg_q - 3'd1) begin
                        state_d = S_U;
                        y_cnt_d = 2'd0;
                    end else begin
                        y_cnt_d = y_cnt_q + 2'd1;
                    end
                end
            end
            S_U: begin
                if (blk_end) begin
                    state_d = S_V;
                end
            end
            S_V: begin
                if (blk_end) begin
                    mcu_done_d = 1'b1;
                    if (i_en) begin
                        state_d = S_Y;
                        cfg_d   = clamp_y_blocks(i_cfg_y_blocks, Y_MAX);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers; reset discards any partially read block.
    always_ff @(posedge r_sysclk or posedge r_srst) begin
        if (r_srst) begin
            state_q    <= S_IDLE;
            cfg_q      <= 3'd1;
            y_cnt_q    <= 2'd0;
            o_mcu_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            y_cnt_q    <= y_cnt_d;
            o_mcu_done <= mcu_done_d;
        end
    end

`ifdef IDCT_MCU_SCHEDULER_PERF_EN
    // Saturating count of active cycles without an accepted beat, cleared at MCU start from idle.
    always_ff @(posedge r_sysclk or posedge r_srst) begin
        if (r_srst) begin
            o_stall_cnt <= 32'd0;
        end else if ((state_q == S_IDLE) && i_en) begin
            o_stall_cnt <= 32'd0;
        end else if ((state_q != S_IDLE) && !accept && (o_stall_cnt != 32'hFFFF_FFFF)) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
